// File: rtl/randomizer_par.sv
// Parallel 1 + x^14 + x^15 scrambler with valid/ready handshake and per-block reseed.
// Optional feature macro: RANDOMIZER_CHECK_EN exposes the live LFSR state on `check`.
module randomizer_par #(
    parameter int          DATA_W      = 8,
    parameter int          BLOCK_WORDS = 12,
    parameter logic [15:1] SEED_INIT   = 15'b000000010101001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [15:1]       seed,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sob
`ifdef RANDOMIZER_CHECK_EN
    ,
    output logic [15:1]       check
`endif
);

    localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

    logic [15:1]       lfsr_q, lfsr_d;
    logic [15:1]       seed_q, seed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_sob_q, out_sob_d;

    logic              accept;
    logic              last_word;
    logic [15:1]       chain [0:DATA_W];
    logic [DATA_W-1:0] scr;

    // Stage gi scrambles the (gi+1)-th bit in time, i.e. in_data MSB first.
    assign chain[0] = lfsr_q;
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_step
            logic fb;
            assign fb                 = chain[gi][14] ^ chain[gi][15];
            assign scr[DATA_W-1-gi]   = in_data[DATA_W-1-gi] ^ fb;
            assign chain[gi+1]        = {chain[gi][14:1], fb};
        end
    endgenerate

    // With BLOCK_WORDS == 0 the block never ends, so the seed is never reloaded.
    generate
        if (BLOCK_WORDS == 0) begin : g_no_block
            assign last_word = 1'b0;
        end else begin : g_block
            assign last_word = (cnt_q == CNT_W'(BLOCK_WORDS - 1));
        end
    endgenerate

    assign in_ready = !load && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sob_d   = out_sob_q;

        if (load) begin
            seed_d = seed;
            lfsr_d = seed;
            cnt_d  = '0;
        end else if (accept) begin
            if (last_word) begin
                lfsr_d = seed_q;
                cnt_d  = '0;
            end else begin
                lfsr_d = chain[DATA_W];
                // Unframed mode saturates at 1 so only the first word is flagged.
                cnt_d  = (BLOCK_WORDS == 0) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end
        end

        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = scr;
            out_sob_d   = (cnt_q == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q      <= SEED_INIT;
            seed_q      <= SEED_INIT;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sob_q   <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sob_q   <= out_sob_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sob   = out_sob_q;

`ifdef RANDOMIZER_CHECK_EN
    assign check = lfsr_q;
`endif

endmodule

// File: tb/tb_randomizer_par.sv
// Bench for randomizer_par: an 8-bit framed instance (3-word blocks) and a 1-bit
// unframed instance, both checked against a PRBS recurrence model b[n]=b[n-14]^b[n-15].
module tb_randomizer_par;

    localparam logic [15:1] SEED_INIT = 15'b000000010101001;
    localparam int          BW8       = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        ld8, iv8, ir8, ov8, or8, sob8;
    logic [15:1] sd8;
    logic [7:0]  id8, od8;
    logic        ld1, iv1, ir1, ov1, or1, sob1;
    logic [15:1] sd1;
    logic [0:0]  id1, od1;
`ifdef RANDOMIZER_CHECK_EN
    logic [15:1] chk8, chk1;
`endif

    randomizer_par #(.DATA_W(8), .BLOCK_WORDS(BW8), .SEED_INIT(SEED_INIT)) dut8 (
        .clk(clk), .reset(reset), .load(ld8), .seed(sd8),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_sob(sob8)
`ifdef RANDOMIZER_CHECK_EN
        , .check(chk8)
`endif
    );

    randomizer_par #(.DATA_W(1), .BLOCK_WORDS(0), .SEED_INIT(SEED_INIT)) dut1 (
        .clk(clk), .reset(reset), .load(ld1), .seed(sd1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sob(sob1)
`ifdef RANDOMIZER_CHECK_EN
        , .check(chk1)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Model state for dut8: active seed and word position inside the block.
    logic [15:1] m_seed;
    int          m_pos;
    logic [7:0]  last_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Keystream bit n after seeding: history b[15-k] = seed[k], then the recurrence.
    function automatic bit ks_bit(input logic [15:1] sd, input int n);
        bit b [0:1023];
        for (int k = 1; k <= 15; k++) b[15-k] = sd[k];
        for (int j = 15; j <= 15 + n; j++) b[j] = b[j-14] ^ b[j-15];
        return b[15+n];
    endfunction

    function automatic logic [7:0] exp_word(input logic [15:1] sd, input int pos, input logic [7:0] d);
        logic [7:0] e;
        for (int i = 0; i < 8; i++) e[7-i] = d[7-i] ^ ks_bit(sd, pos * 8 + i);
        return e;
    endfunction

    task automatic xfer8(input logic [7:0] d, output logic [7:0] got);
        logic [7:0] e;
        logic       es;
        int         n;
        iv8 = 1'b1; id8 = d; or8 = 1'b1;
        #1;
        n = 0;
        while (!ir8 && n < 20) begin step(); n++; end
        chk("in_ready_wait", ir8, 1'b1);
        e  = exp_word(m_seed, m_pos, d);
        es = (m_pos == 0);
        step();
        iv8 = 1'b0;
        chk("xfer_valid", ov8, 1'b1);
        chk("xfer_data", od8, e);
        chk("xfer_sob", sob8, es);
        $display("xfer8 in=%02h out=%02h exp=%02h sob=%0b pos=%0d", d, od8, e, sob8, m_pos);
        got      = od8;
        last_exp = e;
        m_pos    = (m_pos + 1) % BW8;
    endtask

    task automatic do_load(input logic [15:1] s, input logic ordy);
        ld8 = 1'b1; sd8 = s; iv8 = 1'b1; id8 = 8'($urandom); or8 = ordy;
        #1;
        chk("in_ready_during_load", ir8, 1'b0);
        step();
        ld8 = 1'b0; iv8 = 1'b0;
        m_seed = s;
        m_pos  = 0;
`ifdef RANDOMIZER_CHECK_EN
        chk("check_after_load", chk8, s);
`endif
        $display("load seed=%04h out_ready=%0b", s, ordy);
    endtask

    initial begin
        logic [7:0] got, d;
        logic [7:0] ks_tab [0:5];
        logic       sob_tab [0:5];
        logic       b1;

        ks_tab  = '{8'h00, 8'h06, 8'h00, 8'h00, 8'h06, 8'h00};
        sob_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        reset = 1'b1;
        ld8 = 0; sd8 = '0; iv8 = 0; id8 = '0; or8 = 0;
        ld1 = 0; sd1 = '0; iv1 = 0; id1 = '0; or1 = 0;
        step(); step(); step();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", ov8, 1'b0);
        chk("rst_out_data", od8, 8'h00);
        chk("rst_out_sob", sob8, 1'b0);
        chk("rst_in_ready", ir8, 1'b1);
        chk("rst_out_valid_1b", ov1, 1'b0);
`ifdef RANDOMIZER_CHECK_EN
        chk("rst_check", chk8, SEED_INIT);
`endif
        $display("reset released");

        // Bit-serial equivalence on the 1-bit instance.
        for (int i = 0; i < 96; i++) begin
            b1 = 1'($urandom_range(0, 1));
            iv1 = 1'b1; id1 = b1; or1 = 1'b1;
            step();
            chk("serial_bit", od1, b1 ^ ks_bit(SEED_INIT, i));
            chk("serial_valid", ov1, 1'b1);
            $display("serial i=%0d in=%0b out=%0b", i, b1, od1);
        end
        iv1 = 1'b0;
        step();

        // Keystream and block reseed from seed 1.
        m_seed = SEED_INIT; m_pos = 0;
        do_load(15'h0001, 1'b1);
        for (int k = 0; k < 6; k++) begin
            xfer8(8'h00, got);
            chk("block_word", got, ks_tab[k]);
            chk("block_sob", sob8, sob_tab[k]);
        end

        // Random stream across several blocks.
        for (int k = 0; k < 10; k++) begin
            xfer8(8'($urandom), got);
        end

        // Backpressure: pending word held, in_ready low, nothing lost.
        d = 8'($urandom);
        or8 = 1'b0; iv8 = 1'b1; id8 = d;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", ir8, 1'b0);
            chk("bp_valid", ov8, 1'b1);
            chk("bp_data_stable", od8, last_exp);
            $display("stall cycle %0d out=%02h", k, od8);
            step();
        end
        or8 = 1'b1;
        #1;
        chk("bp_release_ready", ir8, 1'b1);
        step();
        iv8 = 1'b0;
        chk("bp_release_data", od8, exp_word(m_seed, m_pos, d));
        chk("bp_release_sob", sob8, m_pos == 0);
        $display("released out=%02h", od8);
        m_pos = (m_pos + 1) % BW8;
        for (int k = 0; k < 3; k++) xfer8(8'($urandom), got);

        // Load mid-block after word 1 while the output is stalled.
        do_load(15'h1234, 1'b1);
        xfer8(8'($urandom), got);
        xfer8(8'($urandom), got);
        do_load(15'h0001, 1'b0);
        chk("load_keeps_valid", ov8, 1'b1);
        chk("load_keeps_data", od8, last_exp);
        xfer8(8'h00, got);
        chk("load_new_word0", got, 8'h00);
        chk("load_new_sob", sob8, 1'b1);

        // Zero seed passes data through unchanged.
        do_load(15'h0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            xfer8(d, got);
            chk("zero_seed_passthru", got, d);
        end

        // Reset with a pending word.
        xfer8(8'($urandom), got);
        or8 = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_out_valid", ov8, 1'b0);
        chk("rst2_out_data", od8, 8'h00);
`ifdef RANDOMIZER_CHECK_EN
        chk("rst2_check", chk8, SEED_INIT);
`endif
        $display("mid-stream reset");
        m_seed = SEED_INIT; m_pos = 0;
        for (int k = 0; k < 5; k++) xfer8(8'($urandom), got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
